mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
//  Multiply/divide unit with HI/LO registers for the MIPS E stage; sits beside the ALU, upstream of GRF writeback.
//  Runs mult/div over a fixed multi-cycle latency and exposes HI/LO for mfhi/mflo, which reach GRF via the W stage.
//  Raises busy so the stall unit can freeze dependent md-class instructions.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (and MADD* family); must be >=1
//  DIV_CYCLES   10  busy cycles for DIV/DIVU; must be >=1
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   synchronous reset, active-low (reset==0 resets)
//  start       in   1   op valid this cycle
//  op          in   4   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MADD,8 MADDU,9 MSUB,10 MSUBU
//  src_a       in   32  rs operand
//  src_b       in   32  rt operand
//  issue_lock  in   1   1 = instruction squashed; start ignored
//  busy        out  1   operation in flight
//  hi          out  32  HI register
//  lo          out  32  LO register
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-low.
//  - Reset (reset==0 at posedge): state=IDLE, counter=0, hi=0, lo=0, busy=0; aborts any in-flight op, no commit.
//  - Accept = start && !issue_lock && state==IDLE; in BUSY, start is ignored (upstream must stall).
//  - FSM: IDLE -> BUSY on accepted MULT/MULTU/DIV/DIVU/MADD*/MSUB*; BUSY -> IDLE when counter reaches 1.
//  - MTHI/MTLO: accepted in IDLE only; hi (resp. lo) <= src_a at that edge; busy stays 0; no state change.
//  - On accept: result computed from src_a/src_b sampled at that edge into 64-bit temp; counter <= N.
//  - busy=1 for exactly N cycles after the accepting edge; at the Nth edge hi/lo <= temp, busy<=0.
//  - hi/lo hold old values throughout BUSY; mfhi during busy is a stall-unit concern.
//  - NONE or op>10 with start: no effect. op 7-10 without MDU_MADD_EN: no effect.
//  - MULT: signed 32x32 -> 64; {hi,lo}=product. MULTU: unsigned.
//  - DIV: signed; lo=quotient (truncate toward zero), hi=remainder (sign of dividend).
//  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
//  - DIVU: unsigned quotient/remainder.
//  - Divide by zero (src_b==0): still busy DIV_CYCLES; hi/lo unchanged at commit.
//  - Arithmetic is modulo 2^64 on {hi,lo}; no overflow flag.
//  - Accept edge is back-to-back with commit: new op may be accepted the cycle after busy falls.
// CONFIGURATION
//  MDU_MADD_EN defined: ops 7-10 enabled, MULT_CYCLES latency.
//    MADD/MADDU: {hi,lo} <= {hi,lo} + signed/unsigned product.
//    MSUB/MSUBU: {hi,lo} <= {hi,lo} - signed/unsigned product.
//    Accumulator base is {hi,lo} as of the accepting edge.
//  MDU_MADD_EN undefined: ops 7-10 ignored as NONE; no accumulate datapath is synthesised.
// TESTING
//  1 MULT a=0xFFFFFFFF b=2 -> busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//  2 MULTU a=0xFFFFFFFF b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
//    DIV a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  3 MTHI a=0x1234 -> next cycle hi=0x1234, busy=0.
//    Then DIVU b=0 -> busy 10 cycles; hi=0x1234 and lo unchanged.
//  4 MULT accepted; at busy cycle 2 apply start DIVU and MTLO -> both ignored.
//    MULT commits normally; start with issue_lock=1 from IDLE -> no busy, hi/lo unchanged.
//  5 DIV accepted; reset=0 at busy cycle 4 -> next cycle busy=0, hi=0, lo=0; no late commit.
//  6 (MDU_MADD_EN) hi=0,lo=5 then MADD a=3 b=4 -> lo=17.
//    MSUBU a=1 b=18 -> {hi,lo}=0xFFFFFFFF_FFFFFFFF; without macro both ops leave hi/lo unchanged, busy=0.

Source files
------------

// File: rtl/mdu_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_unit : multi-cycle multiply/divide unit with HI/LO registers         |
// | Optional MADD/MADDU/MSUB/MSUBU accumulate ops enabled by MDU_MADD_EN.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        issue_lock,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

  localparam logic [c_cnt_w-1:0] c_mult_n  = c_cnt_w'(MULT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_div_n   = c_cnt_w'(DIV_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_busy = 1'b1;

  localparam logic [3:0] c_op_mult  = 4'd1;
  localparam logic [3:0] c_op_multu = 4'd2;
  localparam logic [3:0] c_op_div   = 4'd3;
  localparam logic [3:0] c_op_divu  = 4'd4;
  localparam logic [3:0] c_op_mthi  = 4'd5;
  localparam logic [3:0] c_op_mtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] c_op_madd  = 4'd7;
  localparam logic [3:0] c_op_maddu = 4'd8;
  localparam logic [3:0] c_op_msub  = 4'd9;
  localparam logic [3:0] c_op_msubu = 4'd10;
`endif

  logic [0:0]         r_state;
  logic [0:0]         w_state_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_next;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [63:0]        r_temp;

  logic               w_accept;
  logic               w_long;
  logic               w_commit;
  logic [c_cnt_w-1:0] w_load_n;
  logic [63:0]        w_temp;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_div_b;
  logic [31:0]        w_abs_a;
  logic [31:0]        w_abs_b;
  logic [31:0]        w_q_mag;
  logic [31:0]        w_r_mag;
  logic [31:0]        w_q_s;
  logic [31:0]        w_r_s;
  logic [31:0]        w_q_u;
  logic [31:0]        w_r_u;

  // Low 64 bits of a sign-extended product equal the signed product.
  assign w_prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Divisor forced nonzero so the dividers never see zero; result is discarded then.
  assign w_div_b = (src_b == 32'd0) ? 32'd1 : src_b;
  assign w_abs_a = src_a[31]   ? (~src_a + 32'd1)   : src_a;
  assign w_abs_b = w_div_b[31] ? (~w_div_b + 32'd1) : w_div_b;
  assign w_q_mag = w_abs_a / w_abs_b;
  assign w_r_mag = w_abs_a % w_abs_b;
  // Magnitude form makes 0x80000000 / -1 wrap to 0x80000000 naturally.
  assign w_q_s   = (src_a[31] ^ w_div_b[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r_s   = src_a[31] ? (~w_r_mag + 32'd1) : w_r_mag;
  assign w_q_u   = src_a / w_div_b;
  assign w_r_u   = src_a % w_div_b;

  always_comb begin
    w_accept = start && !issue_lock && (r_state == c_st_idle);
    w_long   = 1'b0;
    w_load_n = c_mult_n;
    w_temp   = {r_hi, r_lo};
    case (op)
      c_op_mult: begin
        w_long = 1'b1;
        w_temp = w_prod_s;
      end
      c_op_multu: begin
        w_long = 1'b1;
        w_temp = w_prod_u;
      end
      c_op_div: begin
        w_long   = 1'b1;
        w_load_n = c_div_n;
        if (src_b != 32'd0) w_temp = {w_r_s, w_q_s};
      end
      c_op_divu: begin
        w_long   = 1'b1;
        w_load_n = c_div_n;
        if (src_b != 32'd0) w_temp = {w_r_u, w_q_u};
      end
`ifdef MDU_MADD_EN
      c_op_madd: begin
        w_long = 1'b1;
        w_temp = {r_hi, r_lo} + w_prod_s;
      end
      c_op_maddu: begin
        w_long = 1'b1;
        w_temp = {r_hi, r_lo} + w_prod_u;
      end
      c_op_msub: begin
        w_long = 1'b1;
        w_temp = {r_hi, r_lo} - w_prod_s;
      end
      c_op_msubu: begin
        w_long = 1'b1;
        w_temp = {r_hi, r_lo} - w_prod_u;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      c_st_idle: begin
        if (w_accept && w_long) begin
          w_state_next = c_st_busy;
          w_cnt_next   = w_load_n;
        end
      end
      c_st_busy: begin
        if (r_cnt == c_cnt_one) begin
          w_state_next = c_st_idle;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - c_cnt_one;
        end
      end
      default: w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    busy     = (r_state == c_st_busy);
    w_commit = (r_state == c_st_busy) && (r_cnt == c_cnt_one);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_temp <= '0;
    end else begin
      if (w_accept && w_long) r_temp <= w_temp;
      if (w_commit) begin
        r_hi <= r_temp[63:32];
        r_lo <= r_temp[31:0];
      end else if (w_accept && (op == c_op_mthi)) begin
        r_hi <= src_a;
      end else if (w_accept && (op == c_op_mtlo)) begin
        r_lo <= src_a;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// Testbench for mdu_unit: directed spec vectors plus random ops against a 64-bit arithmetic model.
module tb_mdu_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        issue_lock;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .issue_lock(issue_lock), .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int latency(input logic [3:0] o);
    case (o)
      4'd1, 4'd2: return MC;
      4'd3, 4'd4: return DC;
`ifdef MDU_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    int sa32, sb32;
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa32 = a; sb32 = b;
    sa = longint'(sa32); sb = longint'(sb32);
    ua = a; ub = b;
    case (o)
      4'd1: return sa * sb;
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 0) return acc;
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 0) return acc;
        return {a % b, a / b};
      end
      4'd5: return {a, acc[31:0]};
      4'd6: return {acc[63:32], a};
`ifdef MDU_MADD_EN
      4'd7:  return acc + 64'(sa * sb);
      4'd8:  return acc + 64'(ua * ub);
      4'd9:  return acc - 64'(sa * sb);
      4'd10: return acc - 64'(ua * ub);
`endif
      default: return acc;
    endcase
  endfunction

  // Called at a negedge; drives one op and follows it through commit.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic lock);
    logic [63:0] exp;
    int n;
    n   = lock ? 0 : latency(o);
    exp = lock ? {m_hi, m_lo} : model(o, a, b, {m_hi, m_lo});
    start = 1'b1; op = o; src_a = a; src_b = b; issue_lock = lock;
    @(negedge clk);
    start = 1'b0; issue_lock = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("busy_high op%0d c%0d", o, i), 64'(busy), 64'd1);
      if (i == n - 1) check($sformatf("hold op%0d", o), {hi, lo}, {m_hi, m_lo});
      @(negedge clk);
    end
    check($sformatf("busy_low op%0d", o), 64'(busy), 64'd0);
    check($sformatf("hilo op%0d a=%h b=%h", o, a, b), {hi, lo}, exp);
    {m_hi, m_lo} = exp;
  endtask

  initial begin
    logic [63:0] exp;
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    logic        rl;
    reset = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; issue_lock = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("t1_mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("t2_multu", {hi, lo}, 64'h00000001_FFFFFFFE);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("t2_div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf", {hi, lo}, 64'h00000000_80000000);

    run_op(4'd5, 32'h1234, 32'd0, 1'b0);
    check("t3_mthi", 64'(hi), 64'h1234);
    run_op(4'd4, 32'd5, 32'd0, 1'b0);
    check("t3_divu0", {hi, lo}, 64'h00001234_80000000);

    // MULT with ignored DIVU and MTLO issued while busy
    exp = model(4'd1, 32'd7, 32'hFFFFFFFD, {m_hi, m_lo});
    start = 1'b1; op = 4'd1; src_a = 32'd7; src_b = 32'hFFFFFFFD;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy1", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b1; op = 4'd4; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    op = 4'd6; src_a = 32'd55;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy4", 64'(busy), 64'd1);
    @(negedge clk);
    check("t4_busy5", 64'(busy), 64'd1);
    check("t4_hold", {hi, lo}, {m_hi, m_lo});
    @(negedge clk);
    check("t4_done", 64'(busy), 64'd0);
    check("t4_mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    check("t4_model", {hi, lo}, exp);
    {m_hi, m_lo} = exp;
    run_op(4'd1, 32'd9, 32'd9, 1'b1);

    // Reset in the middle of a DIV aborts it
    start = 1'b1; op = 4'd3; src_a = 32'd100; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("t5_busy", 64'(busy), 64'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t5_busy_rst", 64'(busy), 64'd0);
    check("t5_hilo_rst", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    repeat (12) @(negedge clk);
    check("t5_no_commit", {hi, lo}, 64'd0);
    check("t5_idle", 64'(busy), 64'd0);

    run_op(4'd5, 32'd0, 32'd0, 1'b0);
    run_op(4'd6, 32'd5, 32'd0, 1'b0);
    run_op(4'd7, 32'd3, 32'd4, 1'b0);
`ifdef MDU_MADD_EN
    check("t6_madd", {hi, lo}, 64'd17);
`else
    check("t6_madd_off", {hi, lo}, 64'd5);
`endif
    run_op(4'd10, 32'd1, 32'd18, 1'b0);
`ifdef MDU_MADD_EN
    check("t6_msubu", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
`else
    check("t6_msubu_off", {hi, lo}, 64'd5);
`endif

    for (int k = 0; k < 40; k++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      rl = ($urandom_range(0, 7) == 0);
      run_op(ro, ra, rb, rl);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
